// File: rtl/irq_trap_sequencer_pkg.sv
// Shared machine-mode definitions: privilege levels, interrupt cause codes,
// trap sequencer state encoding and the fixed-priority cause picker.
package irq_trap_sequencer_pkg;

    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    localparam logic [5:0] CAUSE_MEI = 6'd11;
    localparam logic [5:0] CAUSE_MSI = 6'd3;
    localparam logic [5:0] CAUSE_MTI = 6'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_TAKE  = 2'b10,
        ST_FLUSH = 2'b11
    } trap_state_t;

    // masked = {MEI, MTI, MSI}; MEI > MSI > MTI
    function automatic logic [5:0] pick_cause(input logic [2:0] masked);
        logic [5:0] cause;
        cause = 6'd0;
        if (masked[2])
            cause = CAUSE_MEI;
        else if (masked[0])
            cause = CAUSE_MSI;
        else if (masked[1])
            cause = CAUSE_MTI;
        return cause;
    endfunction

endpackage

// File: rtl/irq_trap_sequencer_if.sv
// Interrupt request, CSR and pipeline-control bundle between the trap
// sequencer (slave) and the core/CSR side (master).
interface irq_trap_sequencer_if;

    logic        ext_irq_req;
    logic        tmr_irq_req;
    logic        sw_irq_req;
    logic        csr_meie;
    logic        csr_mtie;
    logic        csr_msie;
    logic        csr_rmie;
    logic        g_exception;
    logic        cmd_mret_ex;
    logic        jump_in_ex;
    logic        stall;
    logic [29:0] csr_mtvec_ex;

    logic [2:0]  irq_pend;
    logic        g_interrupt;
    logic [1:0]  g_interrupt_priv;
    logic [5:0]  irq_cause;
    logic        int_hold;
    logic        int_jump;
    logic [29:0] int_jump_adr;
    logic        int_flush;

    modport slave (
        input  ext_irq_req, tmr_irq_req, sw_irq_req,
        input  csr_meie, csr_mtie, csr_msie, csr_rmie,
        input  g_exception, cmd_mret_ex, jump_in_ex, stall, csr_mtvec_ex,
        output irq_pend, g_interrupt, g_interrupt_priv, irq_cause,
        output int_hold, int_jump, int_jump_adr, int_flush
    );

    modport master (
        output ext_irq_req, tmr_irq_req, sw_irq_req,
        output csr_meie, csr_mtie, csr_msie, csr_rmie,
        output g_exception, cmd_mret_ex, jump_in_ex, stall, csr_mtvec_ex,
        input  irq_pend, g_interrupt, g_interrupt_priv, irq_cause,
        input  int_hold, int_jump, int_jump_adr, int_flush
    );

endinterface

// File: rtl/irq_trap_sequencer_irq_sync.sv
// Multi-flop synchroniser for the asynchronous external IRQ level.
module irq_trap_sequencer_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_chain <= '0;
        else
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt arbiter and trap-entry sequencer.
//   state    | meaning
//   ST_IDLE  | no trap in progress, watching take_ok
//   ST_ARM   | IF/ID held, waiting for a quiet EX to latch cause and target
//   ST_TAKE  | one-cycle trap pulse, PC redirect, flush starts
//   ST_FLUSH | flush held for the remaining FLUSH_CYCLES-1 cycles
module irq_trap_sequencer
    import irq_trap_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    irq_trap_sequencer_if.slave bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    trap_state_t r_state;
    trap_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic [5:0]  r_irq_cause;
    logic [29:0] r_jump_adr;

    logic        w_ext_sync;
    logic [2:0]  w_pend;
    logic [2:0]  w_masked;
    logic        w_take_ok;
    logic [5:0]  w_cause;
    logic        w_latch;
    logic        w_load;
    logic        w_dec;
    logic        w_g_int;
    logic        w_hold;
    logic        w_jump;
    logic        w_flush;

    irq_trap_sequencer_irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.ext_irq_req),
        .o_sync  (w_ext_sync)
    );

    assign w_pend    = {w_ext_sync, bus.tmr_irq_req, bus.sw_irq_req};
    assign w_masked  = w_pend & {bus.csr_meie, bus.csr_mtie, bus.csr_msie};
    assign w_take_ok = (|w_masked) & bus.csr_rmie;
    assign w_cause   = pick_cause(w_masked);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_g_int     = 1'b0;
        w_hold      = 1'b0;
        w_jump      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // a same-cycle exception or mret owns the pipeline this cycle
                if (w_take_ok && !bus.g_exception && !bus.cmd_mret_ex)
                    w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                w_hold = 1'b1;
                if (!w_take_ok) begin
                    w_state_nxt = ST_IDLE;
                end else if (!bus.stall && !bus.jump_in_ex && !bus.g_exception) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_TAKE;
                end
            end
            ST_TAKE: begin
                w_g_int     = 1'b1;
                w_jump      = 1'b1;
                w_flush     = 1'b1;
                w_hold      = 1'b1;
                w_load      = 1'b1;
                w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                w_hold  = 1'b1;
                w_dec   = 1'b1;
                // the TAKE cycle already counted as the first flush cycle
                if (r_cnt <= 4'd1)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_irq_cause <= 6'd0;
            r_jump_adr  <= 30'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load)
                r_cnt <= FLUSH_LOAD;
            else if (w_dec && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            if (w_latch) begin
                r_irq_cause <= w_cause;
                r_jump_adr  <= bus.csr_mtvec_ex;
            end
        end
    end

    assign bus.irq_pend         = w_pend;
    assign bus.g_interrupt      = w_g_int;
    assign bus.g_interrupt_priv = M_MODE;
    assign bus.irq_cause        = r_irq_cause;
    assign bus.int_hold         = w_hold;
    assign bus.int_jump         = w_jump;
    assign bus.int_jump_adr     = r_jump_adr;
    assign bus.int_flush        = w_flush;

endmodule
